rtc_bus_arbiter: RTL and testbench

- Shares the single RTC transaction engine (multiplexed address/data bus, CS/RD/WR/AoD sequencing) among four requesters: init, user write, chrono, periodic read.
- One transaction per grant, fixed priority with a starvation guard for the periodic reader.
- Lock option lets a requester issue back-to-back transactions (init register sweep).
- Response timeout so a hung bus never blocks the system.

---
 rtl/rtc_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter
// Shares one RTC transaction engine among NREQ requesters. One transaction
// is issued per grant. Priority is fixed (index 0 highest), and a starvation
// guard forces a grant to the lowest-priority requester (the periodic reader).
// A lock lets the owner issue back-to-back transactions without
// re-arbitration. A response timeout guarantees that a hung bus still
// completes, with err set.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req/lock/we           per-requester request, lock-hold, write flag
//   addr/wdata            packed 8-bit fields, requester i at [8i+7:8i]
//   gnt                   one-hot grant, held from grant through DONE/LOCKED
//   ack, err              one-cycle completion pulse (err = timed out)
//   rdata                 data of the last successful read
//   busy                  arbiter not idle
//   cmd_*                 command handshake towards the engine
//   rsp_valid, rsp_data   engine completion and read data
module rtc_bus_arbiter #(
  parameter int NREQ         = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [NREQ-1:0]     we,
  input  logic [8*NREQ-1:0]   addr,
  input  logic [8*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     ack,
  output logic                err,
  output logic [7:0]          rdata,
  output logic                busy,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_we,
  output logic [7:0]          cmd_addr,
  output logic [7:0]          cmd_wdata,
  input  logic                rsp_valid,
  input  logic [7:0]          rsp_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, LOCKED} state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] win;
  logic [TW-1:0] timer;
  logic [SW-1:0] starve_cnt;

  // Winner selection: the starved periodic reader first, else the lowest set index.
  always_comb begin
    win = '0;
    if (starve_cnt == SW'(STARVE_LIMIT) && req[NREQ-1]) begin
      win = IW'(NREQ - 1);
    end else begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req[i]) win = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      gnt        <= '0;
      ack        <= '0;
      err        <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      timer      <= '0;
      starve_cnt <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= win;
            gnt       <= NREQ'(1) << win;
            cmd_we    <= we[win];
            cmd_addr  <= addr[8*win +: 8];
            cmd_wdata <= wdata[8*win +: 8];
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
            if (win == IW'(NREQ - 1)) begin
              starve_cnt <= '0;
            end else if (req[NREQ-1] && starve_cnt != SW'(STARVE_LIMIT)) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            timer     <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving on the timeout cycle still counts as success.
          if (rsp_valid) begin
            if (!cmd_we) rdata <= rsp_data;
            ack   <= gnt;
            state <= DONE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            ack   <= gnt;
            state <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          if (lock[owner]) begin
            state <= LOCKED;
          end else begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        LOCKED: begin
          // Only the owner may continue; relatching skips the starve update.
          if (req[owner]) begin
            cmd_we    <= we[owner];
            cmd_addr  <= addr[8*owner +: 8];
            cmd_wdata <= wdata[8*owner +: 8];
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end else begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          gnt       <= '0;
          busy      <= 1'b0;
          cmd_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
module tb_rtc_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, lock, we;
  logic [31:0] addr, wdata;
  logic [3:0]  gnt, ack;
  logic        err, busy, cmd_valid, cmd_ready, cmd_we, rsp_valid;
  logic [7:0]  rdata, cmd_addr, cmd_wdata, rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rtc_bus_arbiter #(.NREQ(4), .STARVE_LIMIT(8), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .err(err),
    .rdata(rdata), .busy(busy), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From ISSUE: accept, wait dly cycles, respond; returns in the DONE cycle.
  task automatic do_txn(input int dly, input logic [7:0] data);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    repeat (dly) step();
    rsp_valid = 1'b1;
    rsp_data  = data;
    step();
    rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0; lock = '0; we = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    addr  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    wdata = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    do_reset();

    // Reset state
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cmdv", 32'(cmd_valid), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_addr", 32'(cmd_addr), 32'h0);

    // Priority: req 1 and 3, requester 1 reads, requester 3 writes
    req = 4'b1010; we = 4'b1000;
    step();
    chk("p_gnt", 32'(gnt), 32'h2);
    chk("p_addr", 32'(cmd_addr), 32'hA1);
    chk("p_cmdv", 32'(cmd_valid), 32'h1);
    chk("p_busy", 32'(busy), 32'h1);
    chk("p_we", 32'(cmd_we), 32'h0);
    do_txn(3, 8'h59);
    chk("p_ack", 32'(ack), 32'h2);
    chk("p_err", 32'(err), 32'h0);
    chk("p_rdata", 32'(rdata), 32'h59);
    chk("p_gnt_done", 32'(gnt), 32'h2);
    req = 4'b1000;
    step();
    chk("p_idle_gnt", 32'(gnt), 32'h0);
    chk("p_idle_ack", 32'(ack), 32'h0);
    chk("p_idle_busy", 32'(busy), 32'h0);
    step();
    chk("w_gnt", 32'(gnt), 32'h8);
    chk("w_we", 32'(cmd_we), 32'h1);
    chk("w_wdata", 32'(cmd_wdata), 32'hD3);
    do_txn(1, 8'hAA);
    chk("w_ack", 32'(ack), 32'h8);
    chk("w_rdata_kept", 32'(rdata), 32'h59);
    req = 4'b0000;
    step();

    // Starvation guard: 8 grants to 0, 9th to 3, then counter cleared
    do_reset();
    req = 4'b1001; we = 4'b0000;
    for (int g = 0; g < 10; g++) begin
      step();
      chk($sformatf("starve_gnt%0d", g), 32'(gnt), (g == 8) ? 32'h8 : 32'h1);
      do_txn(0, 8'h00);
      step();
    end
    req = 4'b0000;
    step();

    // Lock: 5 back-to-back writes by requester 0 while req[2] pends
    do_reset();
    req = 4'b0101; lock = 4'b0001; we = 4'b0101;
    wdata[7:0] = 8'h50;
    step();
    chk("lk_gnt0", 32'(gnt), 32'h1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("lk_wdata%0d", k), 32'(cmd_wdata), 32'(8'h50 + k));
      do_txn(0, 8'h00);
      chk($sformatf("lk_ack%0d", k), 32'(ack), 32'h1);
      if (k < 4) begin
        step();
        chk($sformatf("lk_hold%0d", k), 32'({busy, gnt}), 32'h11);
        wdata[7:0] = 8'(8'h51 + k);
        step();
        chk($sformatf("lk_issue%0d", k), 32'({cmd_valid, gnt}), 32'h11);
      end else begin
        lock = 4'b0000; req = 4'b0100;
        step();
        chk("lk_release", 32'(gnt), 32'h0);
        step();
        chk("lk_gnt2", 32'(gnt), 32'h4);
        do_txn(0, 8'h00);
        req = 4'b0000;
        step();
      end
    end

    // Timeout: no response after accept
    do_reset();
    req = 4'b0001;
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    n = 0;
    while (ack == 4'b0000 && n < 300) begin
      step();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd255);
    chk("to_ack", 32'(ack), 32'h1);
    chk("to_err", 32'(err), 32'h1);
    chk("to_rdata", 32'(rdata), 32'h0);
    req = 4'b0000;
    step();
    chk("to_idle", 32'({busy, err, gnt}), 32'h0);

    // Reset in WAIT, then a late response is ignored
    req = 4'b0010;
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; req = 4'b0000;
    chk("rw_gnt", 32'(gnt), 32'h0);
    chk("rw_ack", 32'(ack), 32'h0);
    chk("rw_busy", 32'({busy, cmd_valid}), 32'h0);
    rsp_valid = 1'b1; rsp_data = 8'h77;
    step();
    rsp_valid = 1'b0;
    chk("rw_late_ack", 32'(ack), 32'h0);
    chk("rw_late_rdata", 32'(rdata), 32'h0);
    chk("rw_late_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
